img_rect_gen: RTL and testbench

Parametrised pixel source for the VGA core: holds the current raster position, advances it one pixel per fetch request, and returns the colour for that position. Colour comes from up to NUM_RECTS programmable rectangles over a background, a colour-bar test pattern, or a checkerboard. It sits between the configuration master and the VGA core, driven from the pixel clock. Rectangle and mode settings are double-buffered and commit only at frame boundaries, so a frame never shows a mix of old and new settings.

---
 rtl/img_rect_gen.sv | 200 ++++++++++++++++++++
 tb/tb_img_rect_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_rect_gen.sv
`default_nettype none
// ============================================================================
//  Module   : img_rect_gen
//  Purpose  : Raster-position pixel source for the VGA core. Colour comes from
//             programmable rectangles over a background, colour bars or a
//             checkerboard. Settings are double-buffered and are committed
//             only at frame boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module img_rect_gen #(
    parameter int                  H_PIXELS   = 640,
    parameter int                  V_LINES    = 480,
    parameter int                  CH_W       = 1,
    parameter int                  NUM_RECTS  = 4,
    parameter logic [3*CH_W-1:0]   BG_COLOR   = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}},
    parameter int                  CHECK_LOG2 = 4,
    localparam int                 X_W        = $clog2(H_PIXELS),
    localparam int                 Y_W        = $clog2(V_LINES),
    localparam int                 PIX_W      = 3 * CH_W,
    localparam int                 IDX_W      = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_fetch_next_pixel,
    input  logic             i_frame_start,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic             i_cfg_en,
    input  logic [X_W-1:0]   i_cfg_x0,
    input  logic [X_W-1:0]   i_cfg_x1,
    input  logic [Y_W-1:0]   i_cfg_y0,
    input  logic [Y_W-1:0]   i_cfg_y1,
    input  logic [PIX_W-1:0] i_cfg_color,
    input  logic [1:0]       i_mode,
    output logic [PIX_W-1:0] o_pixel_rgb,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic             o_frame_done
);

    localparam int BAR_W = H_PIXELS / 8;
    localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [1:0] MODE_RECT  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;

    typedef struct packed {
        logic             en;
        logic [X_W-1:0]   x0;
        logic [X_W-1:0]   x1;
        logic [Y_W-1:0]   y0;
        logic [Y_W-1:0]   y1;
        logic [PIX_W-1:0] color;
    } rect_t;

    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [2:0]      b_q, b_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            done_q, done_d;
    logic [1:0]      mode_sh_q, mode_act_q;

    logic            w_last_x;
    logic            w_last_y;
    logic            w_commit;

    logic [NUM_RECTS-1:0]            w_hit;
    logic [NUM_RECTS-1:0][PIX_W-1:0] w_col;
    logic [PIX_W-1:0]                w_pix;

    assign w_last_x = (x_q == X_W'(H_PIXELS - 1));
    assign w_last_y = (y_q == Y_W'(V_LINES - 1));
    // Frame start always commits; otherwise only a fetch that wraps the frame does.
    assign w_commit = i_frame_start | (i_fetch_next_pixel & w_last_x & w_last_y);

    // Next raster position, bar counter and frame-done pulse; frame start beats fetch.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        b_d    = b_q;
        bcnt_d = bcnt_q;
        done_d = 1'b0;
        if (i_frame_start) begin
            x_d    = '0;
            y_d    = '0;
            b_d    = '0;
            bcnt_d = '0;
        end else if (i_fetch_next_pixel) begin
            if (w_last_x) begin
                x_d    = '0;
                b_d    = '0;
                bcnt_d = '0;
                y_d    = w_last_y ? '0 : y_q + 1'b1;
                done_d = w_last_y;
            end else begin
                x_d = x_q + 1'b1;
                if (bcnt_q == BC_W'(BAR_W - 1)) begin
                    bcnt_d = '0;
                    b_d    = b_q + 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end
    end

    // Position state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            b_q    <= '0;
            bcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            b_q    <= b_d;
            bcnt_q <= bcnt_d;
            done_q <= done_d;
        end
    end

    // Mode shadow follows the input every cycle; active copy takes the pre-update shadow on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_sh_q  <= MODE_RECT;
            mode_act_q <= MODE_RECT;
        end else begin
            mode_sh_q <= i_mode;
            if (w_commit) begin
                mode_act_q <= mode_sh_q;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RECTS; k++) begin : g_rect
            rect_t sh_q;
            rect_t act_q;
            logic  w_sel;

            assign w_sel = i_cfg_we && (i_cfg_idx == IDX_W'(k));

            // Shadow written by config port; active copies the old shadow on commit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sh_q  <= '0;
                    act_q <= '0;
                end else begin
                    if (w_commit) begin
                        act_q <= sh_q;
                    end
                    if (w_sel) begin
                        sh_q <= '{en: i_cfg_en, x0: i_cfg_x0, x1: i_cfg_x1,
                                  y0: i_cfg_y0, y1: i_cfg_y1, color: i_cfg_color};
                    end
                end
            end

            // Inverted bounds fail one of the compares, so they never hit.
            assign w_hit[k] = act_q.en &&
                              (x_q >= act_q.x0) && (x_q <= act_q.x1) &&
                              (y_q >= act_q.y0) && (y_q <= act_q.y1);
            assign w_col[k] = act_q.color;
        end
    endgenerate

    // Pixel colour from registered state only; scanning down makes the lowest hit index win.
    always_comb begin
        logic             rect_hit;
        logic [PIX_W-1:0] rect_col;
        logic [PIX_W-1:0] check_col;
        logic [PIX_W-1:0] bars_col;
        rect_hit  = 1'b0;
        rect_col  = '0;
        check_col = {PIX_W{x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]}};
        bars_col  = {{CH_W{b_q[2]}}, {CH_W{b_q[1]}}, {CH_W{b_q[0]}}};
        for (int k = NUM_RECTS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                rect_hit = 1'b1;
                rect_col = w_col[k];
            end
        end
        case (mode_act_q)
            MODE_RECT:  w_pix = rect_hit ? rect_col : BG_COLOR;
            MODE_BARS:  w_pix = bars_col;
            MODE_CHECK: w_pix = check_col;
            default:    w_pix = rect_hit ? rect_col : check_col;
        endcase
    end

    assign o_pixel_rgb  = w_pix;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_img_rect_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_rect_gen
//  Purpose  : Directed self-checking bench for img_rect_gen on a reduced
//             64x48 raster (bar width 8, checker square 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_img_rect_gen;

    localparam int H = 64;
    localparam int V = 48;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch;
    logic       frame_start;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic       cfg_en;
    logic [5:0] cfg_x0, cfg_x1;
    logic [5:0] cfg_y0, cfg_y1;
    logic [2:0] cfg_color;
    logic [1:0] mode;
    logic [2:0] pixel_rgb;
    logic [5:0] pos_x;
    logic [5:0] pos_y;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int pulse_at;

    img_rect_gen #(
        .H_PIXELS (H),
        .V_LINES  (V)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_fetch_next_pixel (fetch),
        .i_frame_start      (frame_start),
        .i_cfg_we           (cfg_we),
        .i_cfg_idx          (cfg_idx),
        .i_cfg_en           (cfg_en),
        .i_cfg_x0           (cfg_x0),
        .i_cfg_x1           (cfg_x1),
        .i_cfg_y0           (cfg_y0),
        .i_cfg_y1           (cfg_y1),
        .i_cfg_color        (cfg_color),
        .i_mode             (mode),
        .o_pixel_rgb        (pixel_rgb),
        .o_x                (pos_x),
        .o_y                (pos_y),
        .o_frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rect(input logic [1:0] idx, input logic en,
                            input logic [5:0] x0, input logic [5:0] x1,
                            input logic [5:0] y0, input logic [5:0] y1,
                            input logic [2:0] col);
        cfg_idx   = idx;
        cfg_en    = en;
        cfg_x0    = x0;
        cfg_x1    = x1;
        cfg_y0    = y0;
        cfg_y1    = y1;
        cfg_color = col;
    endtask

    task automatic write_rect(input logic [1:0] idx, input logic en,
                              input logic [5:0] x0, input logic [5:0] x1,
                              input logic [5:0] y0, input logic [5:0] y1,
                              input logic [2:0] col);
        set_rect(idx, en, x0, x1, y0, y1, col);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Fetch one pixel per cycle until the target position, bounded by one frame.
    task automatic advance_to(input string tag, input logic [5:0] tx, input logic [5:0] ty);
        int n = 0;
        while (!(pos_x == tx && pos_y == ty) && n < H * V + 8) begin
            fetch = 1'b1;
            tick();
            n++;
        end
        fetch = 1'b0;
        check({tag, "_pos"}, 32'({pos_y, pos_x}), 32'({ty, tx}));
    endtask

    initial begin
        reset       = 1'b1;
        fetch       = 1'b0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        mode        = 2'd0;
        set_rect(2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 3'd0);

        // Reset values
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_x",    32'(pos_x),      32'd0);
        check("rst_y",    32'(pos_y),      32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_rgb",  32'(pixel_rgb),  32'h5);

        // Rectangle 0 in shadow only: not visible before commit
        write_rect(2'd0, 1'b1, 6'd10, 6'd59, 6'd30, 6'd33, 3'b111);
        advance_to("pre", 6'd10, 6'd30);
        check("pre_commit_rgb", 32'(pixel_rgb), 32'h5);
        commit();
        check("fs_x", 32'(pos_x), 32'd0);
        check("fs_y", 32'(pos_y), 32'd0);
        advance_to("r0a", 6'd9, 6'd30);
        check("r0_left_out", 32'(pixel_rgb), 32'h5);
        advance_to("r0b", 6'd10, 6'd30);
        check("r0_left_in", 32'(pixel_rgb), 32'h7);
        advance_to("r0c", 6'd59, 6'd30);
        check("r0_right_in", 32'(pixel_rgb), 32'h7);
        advance_to("r0d", 6'd60, 6'd30);
        check("r0_right_out", 32'(pixel_rgb), 32'h5);
        advance_to("r0e", 6'd10, 6'd34);
        check("r0_below", 32'(pixel_rgb), 32'h5);

        // Priority: full-screen rect 1 under rect 0
        write_rect(2'd1, 1'b1, 6'd0, 6'd63, 6'd0, 6'd47, 3'b010);
        commit();
        advance_to("pr1", 6'd20, 6'd31);
        check("prio_r0", 32'(pixel_rgb), 32'h7);
        advance_to("pr2", 6'd40, 6'd40);
        check("prio_r1", 32'(pixel_rgb), 32'h2);

        // Full frame with continuous fetch and a mid-frame shadow write
        commit();
        pulses   = 0;
        pulse_at = -1;
        fetch    = 1'b1;
        for (int i = 1; i <= H * V; i++) begin
            tick();
            if (frame_done) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 1000) begin
                set_rect(2'd1, 1'b1, 6'd0, 6'd63, 6'd0, 6'd47, 3'b100);
                cfg_we = 1'b1;
            end
            if (i == 1001) cfg_we = 1'b0;
            if (i == 1002) check("midframe_old", 32'(pixel_rgb), 32'h2);
        end
        fetch = 1'b0;
        check("wrap_pulses",   32'(pulses),     32'd1);
        check("wrap_pulse_at", 32'(pulse_at),   32'(H * V));
        check("wrap_done",     32'(frame_done), 32'd1);
        check("wrap_x",        32'(pos_x),      32'd0);
        check("wrap_y",        32'(pos_y),      32'd0);
        check("wrap_new_col",  32'(pixel_rgb),  32'h4);
        tick();
        check("wrap_done_1cyc", 32'(frame_done), 32'd0);

        // Colour bars
        mode = 2'd1;
        tick();
        commit();
        check("bar_x0", 32'(pixel_rgb), 32'h0);
        advance_to("b1", 6'd7, 6'd0);
        check("bar_x7", 32'(pixel_rgb), 32'h0);
        advance_to("b2", 6'd8, 6'd0);
        check("bar_x8", 32'(pixel_rgb), 32'h1);
        advance_to("b3", 6'd63, 6'd0);
        check("bar_x63", 32'(pixel_rgb), 32'h7);
        advance_to("b4", 6'd0, 6'd1);
        check("bar_line_rst", 32'(pixel_rgb), 32'h0);
        advance_to("b5", 6'd8, 6'd1);
        check("bar_line1_x8", 32'(pixel_rgb), 32'h1);

        // Checkerboard
        mode = 2'd2;
        tick();
        commit();
        check("chk_0_0", 32'(pixel_rgb), 32'h0);
        advance_to("c1", 6'd16, 6'd0);
        check("chk_16_0", 32'(pixel_rgb), 32'h7);
        advance_to("c2", 6'd15, 6'd16);
        check("chk_15_16", 32'(pixel_rgb), 32'h7);
        advance_to("c3", 6'd16, 6'd16);
        check("chk_16_16", 32'(pixel_rgb), 32'h0);

        // Rectangles over checkerboard (rect 1 disabled)
        mode = 2'd3;
        write_rect(2'd1, 1'b0, 6'd0, 6'd63, 6'd0, 6'd47, 3'b100);
        commit();
        check("m3_0_0", 32'(pixel_rgb), 32'h0);
        advance_to("m1", 6'd16, 6'd0);
        check("m3_16_0", 32'(pixel_rgb), 32'h7);
        advance_to("m2", 6'd20, 6'd31);
        check("m3_rect", 32'(pixel_rgb), 32'h7);
        advance_to("m3", 6'd60, 6'd31);
        check("m3_bg_chk", 32'(pixel_rgb), 32'h0);

        // Frame start with fetch, plus write in the commit cycle
        mode = 2'd0;
        tick();
        commit();
        check("m0_back_bg", 32'(pixel_rgb), 32'h5);
        advance_to("col", 6'd5, 6'd3);
        set_rect(2'd2, 1'b1, 6'd0, 6'd63, 6'd0, 6'd47, 3'b011);
        cfg_we      = 1'b1;
        fetch       = 1'b1;
        frame_start = 1'b1;
        tick();
        cfg_we      = 1'b0;
        fetch       = 1'b0;
        frame_start = 1'b0;
        check("col_x",    32'(pos_x),      32'd0);
        check("col_y",    32'(pos_y),      32'd0);
        check("col_done", 32'(frame_done), 32'd0);
        check("col_rgb",  32'(pixel_rgb),  32'h5);
        tick();
        check("col_done2", 32'(frame_done), 32'd0);
        commit();
        check("col_r2_vis", 32'(pixel_rgb), 32'h3);
        advance_to("col2", 6'd10, 6'd30);
        check("col_r0_over_r2", 32'(pixel_rgb), 32'h7);

        // Reset mid-frame clears position and all configuration
        advance_to("mr", 6'd12, 6'd30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_x",    32'(pos_x),      32'd0);
        check("mrst_y",    32'(pos_y),      32'd0);
        check("mrst_done", 32'(frame_done), 32'd0);
        check("mrst_rgb",  32'(pixel_rgb),  32'h5);
        commit();
        check("mrst_sh_clr", 32'(pixel_rgb), 32'h5);
        advance_to("mr2", 6'd10, 6'd30);
        check("mrst_r0_clr", 32'(pixel_rgb), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
